seq_div_top: RTL

//  Multi-cycle restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor -> WIDTH-bit quotient + remainder.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 24 ++
 rtl/seq_div_top.sv | 112 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Optional overflow/divide-by-zero detection is enabled by DIV_OVF_DETECT_EN.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {R,Q}, trial subtract D.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH:0]   o_r,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH+1:0] w_sh;
    logic [WIDTH+1:0] w_dx;
    logic             w_ge;

    assign w_sh = {i_r, i_q[WIDTH-1]};
    assign w_dx = {2'b00, i_d};
    assign w_ge = (w_sh >= w_dx);

    // R stays below D between steps, so the dropped MSB is always zero
    assign o_r = (WIDTH+1)'(w_ge ? (w_sh - w_dx) : w_sh);
    assign o_q = {i_q[WIDTH-2:0], w_ge};

endmodule

// File: rtl/seq_div_top.sv
// Multi-cycle restoring divider, 2W/W -> W quotient and remainder.
// Define DIV_OVF_DETECT_EN to flag divide-by-zero/overflow on err.
module seq_div_top
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem,
    output logic               err
);

    localparam int CW = cnt_w(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_err;
    logic [WIDTH:0]   w_r_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic             w_accept;
    logic             w_last;
    logic             w_ovf;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_OVF_DETECT_EN
    assign w_ovf = (divisor == '0)
                || (dividend[2*WIDTH-1:WIDTH] >= divisor);
`else
    assign w_ovf = 1'b0;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_r (r_r),
        .i_q (r_q),
        .i_d (r_d),
        .o_r (w_r_nx),
        .o_q (w_q_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = w_ovf ? DONE : BUSY;
            BUSY: if (w_last) w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r   <= '0;
            r_q   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept && w_ovf) begin
                        r_q   <= '1;
                        r_r   <= {1'b0, dividend[WIDTH-1:0]};
                        r_err <= 1'b1;
                    end else if (w_accept) begin
                        r_r   <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
                        r_q   <= dividend[WIDTH-1:0];
                        r_d   <= divisor;
                        r_cnt <= '0;
                        r_err <= 1'b0;
                    end
                end
                BUSY: begin
                    r_r   <= w_r_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quot      = r_q;
    assign rem       = r_r[WIDTH-1:0];
    assign err       = r_err;

endmodule
